// File: rtl/rv32i_params.sv
// Shared constants for the rv32i core: datapath width, instruction memory
// geometry, boot address and the canonical NOP encoding.
// Ports: none (package only).
package rv32i_params;

  localparam int DATA_WIDTH   = 32;
  localparam int I_BRAM_DEPTH = 256;
  localparam logic [DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : rv32i_params

// File: rtl/fetch_stage_imem_bram.sv
// Simple dual-port synchronous instruction RAM: one write port, one
// registered read port with enable (1-cycle read latency).
// Ports: i_clk/i_rst (async active-low, clears read register only),
//   i_we/i_waddr/i_wdat write port, i_re/i_raddr read request, o_rdat data.
// Same-word write+read: write-first when IMEM_WRITE_FIRST_EN is defined,
// otherwise read-first (old content returned).
module imem_bram #(
  parameter  int DEPTH = 256,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdat;

  // Storage has no reset so it maps onto block RAM; program survives reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rdat <= '0;
    end else if (i_re) begin
`ifdef IMEM_WRITE_FIRST_EN
      // Forward the word being written this edge to the read port.
      if (i_we && (i_waddr == i_raddr)) begin
        r_rdat <= i_wdat;
      end else begin
        r_rdat <= r_mem[i_raddr];
      end
`else
      r_rdat <= r_mem[i_raddr];
`endif
    end
  end

  assign o_rdat = r_rdat;

endmodule : imem_bram

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register driving a synchronous instruction BRAM.
// Latency: instr is valid one edge after the fetch event (r_enb & !stall).
// Backpressure: stall freezes PC and instr; a redirect squashes that edge's fetch.
// Ports: clk, rst (async active-low), stall, pc_select/pc_in (redirect),
//   w_addr/w_dat/w_enb (program load), r_enb (fetch enable),
//   pc_out, instr, instr_pc, instr_valid.
// Build option: IMEM_WRITE_FIRST_EN selects write-first same-word behaviour.
module fetch_stage
  import rv32i_params::*;
#(
  parameter int                           DATA_WIDTH   = rv32i_params::DATA_WIDTH,
  parameter int                           I_BRAM_DEPTH = rv32i_params::I_BRAM_DEPTH,
  parameter logic [DATA_WIDTH-1:0]        BOOT_ADDR    = rv32i_params::BOOT_ADDR,
  parameter int                           WADDR_W      = $clog2(I_BRAM_DEPTH) + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  pc_select,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [WADDR_W-1:0]    w_addr,
  input  logic [DATA_WIDTH-1:0] w_dat,
  input  logic                  w_enb,
  input  logic                  r_enb,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);

  localparam int AW = $clog2(I_BRAM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr_pc;
  logic                  r_instr_valid;

  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_fetch;
  logic                  w_we;
  logic [AW-1:0]         w_raddr;
  logic [AW-1:0]         w_waddr;

  // Byte-offset bits and PC bits above the memory size are don't-care.
  logic w_unused;
  assign w_unused = &{1'b0, pc_in[1:0], w_addr[1:0], r_pc[1:0]};

  assign w_fetch = r_enb & ~stall;
  // rst is low while reset is asserted, so this masks writes during reset.
  assign w_we    = w_enb & rst;
  assign w_raddr = r_pc[AW+1:2];
  assign w_waddr = w_addr[AW+1:2];

  always_comb begin
    w_pc_next = r_pc;
    if (pc_select) begin
      w_pc_next = {pc_in[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall) begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= BOOT_ADDR;
      r_instr_pc    <= BOOT_ADDR;
      r_instr_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_fetch) begin
        r_instr_pc <= r_pc;
      end
      // A fetch issued on a redirect edge comes from the abandoned path.
      r_instr_valid <= w_fetch & ~pc_select;
    end
  end

  imem_bram #(
    .DEPTH (I_BRAM_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_imem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (w_dat),
    .i_re    (w_fetch),
    .i_raddr (w_raddr),
    .o_rdat  (instr)
  );

  assign pc_out      = r_pc;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, program load, sequential fetch,
// stall, redirect, same-word write/fetch, address wrap, mid-stream reset.
// Ports: none (top-level bench).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_select;
  logic [31:0] pc_in;
  logic [9:0]  w_addr;
  logic [31:0] w_dat;
  logic        w_enb;
  logic        r_enb;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [5];
  logic [31:0] w255;
  logic [31:0] exp_same;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_select   (pc_select),
    .pc_in       (pc_in),
    .w_addr      (w_addr),
    .w_dat       (w_dat),
    .w_enb       (w_enb),
    .r_enb       (r_enb),
    .pc_out      (pc_out),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    words[0] = 32'h1111_0001;
    words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003;
    words[3] = 32'h4444_0004;
    words[4] = 32'h5555_0005;
    w255     = 32'hFFFF_00FF;

    rst = 1'b0; stall = 1'b0; pc_select = 1'b0; pc_in = '0;
    w_addr = '0; w_dat = '0; w_enb = 1'b0; r_enb = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_vld", {31'b0, instr_valid}, 32'h0);
    tick(); tick();

    // Release reset while stalled: nothing may move.
    rst = 1'b1; stall = 1'b1; r_enb = 1'b1;
    tick(); tick();
    chk("stall_pc", pc_out, 32'h0);
    chk("stall_instr", instr, 32'h0);
    chk("stall_vld", {31'b0, instr_valid}, 32'h0);

    // Program load (still stalled, no fetches).
    r_enb = 1'b0; w_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_addr = 10'(i * 4); w_dat = words[i];
      tick();
    end
    w_addr = 10'h3FC; w_dat = w255;
    tick();
    w_enb = 1'b0;
    chk("load_pc", pc_out, 32'h0);

    // Two sequential fetches.
    stall = 1'b0; r_enb = 1'b1;
    tick();
    chk("f0_instr", instr, words[0]);
    chk("f0_pc", pc_out, 32'h4);
    chk("f0_ipc", instr_pc, 32'h0);
    chk("f0_vld", {31'b0, instr_valid}, 32'h1);
    tick();
    chk("f1_instr", instr, words[1]);
    chk("f1_pc", pc_out, 32'h8);

    // Stall for three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_pc", pc_out, 32'h8);
      chk("st_instr", instr, words[1]);
      chk("st_vld", {31'b0, instr_valid}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("f2_instr", instr, words[2]);
    chk("f2_ipc", instr_pc, 32'h8);
    chk("f2_pc", pc_out, 32'hC);
    tick();
    chk("f3_instr", instr, words[3]);
    chk("f3_pc", pc_out, 32'h10);

    // Redirect to 0xE (aligned down to 0xC); that edge's fetch is squashed.
    pc_select = 1'b1; pc_in = 32'h0000_000E;
    tick();
    chk("rd_pc", pc_out, 32'hC);
    chk("rd_vld", {31'b0, instr_valid}, 32'h0);
    pc_select = 1'b0;
    tick();
    chk("rd_instr", instr, words[3]);
    chk("rd_ipc", instr_pc, 32'hC);
    chk("rd_vld2", {31'b0, instr_valid}, 32'h1);
    chk("rd_pc2", pc_out, 32'h10);

    // Same-edge write and fetch of word 4.
    w_enb = 1'b1; w_addr = 10'h010; w_dat = 32'hDEAD_BEEF;
`ifdef IMEM_WRITE_FIRST_EN
    exp_same = 32'hDEAD_BEEF;
`else
    exp_same = words[4];
`endif
    tick();
    w_enb = 1'b0;
    chk("wf_instr", instr, exp_same);
    chk("wf_ipc", instr_pc, 32'h10);
    // Re-read word 4 to confirm the write landed.
    pc_select = 1'b1; pc_in = 32'h10;
    tick();
    pc_select = 1'b0;
    tick();
    chk("wf_reread", instr, 32'hDEAD_BEEF);

    // Wrap: 0x3FC is the last word, 0x400 aliases word 0.
    pc_select = 1'b1; pc_in = 32'h3FC;
    tick();
    pc_select = 1'b0;
    chk("wr_pc", pc_out, 32'h3FC);
    tick();
    chk("wr_instr255", instr, w255);
    chk("wr_pc400", pc_out, 32'h400);
    tick();
    chk("wr_instr0", instr, words[0]);
    chk("wr_ipc", instr_pc, 32'h400);

    // PC wraps modulo 2^32.
    pc_select = 1'b1; pc_in = 32'hFFFF_FFFC;
    tick();
    pc_select = 1'b0;
    chk("top_pc", pc_out, 32'hFFFF_FFFC);
    tick();
    chk("top_wrap_pc", pc_out, 32'h0);
    chk("top_instr", instr, w255);
    chk("top_ipc", instr_pc, 32'hFFFF_FFFC);

    // Mid-stream asynchronous reset; a write attempted during reset is dropped.
    rst = 1'b0;
    #1;
    chk("mr_pc", pc_out, 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_ipc", instr_pc, 32'h0);
    chk("mr_vld", {31'b0, instr_valid}, 32'h0);
    w_enb = 1'b1; w_addr = 10'h000; w_dat = 32'hBAD0_BAD0;
    tick();
    w_enb = 1'b0;
    rst = 1'b1;
    tick();
    chk("mr_f_instr", instr, words[0]);
    chk("mr_f_pc", pc_out, 32'h4);
    chk("mr_f_vld", {31'b0, instr_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_stage
